// File: rtl/xpb_pkg.sv
// Shared constants, types and helpers for the xpb digit-accumulation front-end.
package xpb_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((64'd1 << width) < 64'(value)) width = width + 1;
      return width;
   endfunction

   localparam int unsigned DIGIT_BITS = 5;
   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned WORD_BITS  = 1024;
   localparam int unsigned IDX_BITS   = clog2(NUM_DIGITS);
   // One spare bit above the worst-case sum width keeps the carry-save wrap harmless.
   localparam int unsigned ACC_BITS   = WORD_BITS + IDX_BITS + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

   typedef logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] digits_t;

   typedef struct packed {
      logic [ACC_BITS-1:0] sum;
      logic [ACC_BITS-1:0] carry;
   } cs_pair_t;

endpackage

// File: rtl/csa_3to2.sv
// Purely combinational W-bit 3:2 carry-save compressor.
module csa_3to2 #(
   parameter int unsigned W = 1028
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum_c,
   output logic [W-1:0] carry_c
);

   logic [W-1:0] maj;

   assign sum_c   = a ^ b ^ c;
   assign maj     = (a & b) | (a & c) | (b & c);
   assign carry_c = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/xpb_digit_accumulator.sv
// Walks the job's digits through the xpb LUT bank, one per cycle, and sums the
// returned residues into a carry-save pair handed downstream via valid/ready.
module xpb_digit_accumulator
   import xpb_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_DIGITS*DIGIT_BITS-1:0] in_digits,
   output logic [IDX_BITS-1:0]              lut_sel,
   output logic [DIGIT_BITS-1:0]            lut_digit,
   input  logic [WORD_BITS-1:0]             lut_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ACC_BITS-1:0]              out_sum,
   output logic [ACC_BITS-1:0]              out_carry
);

   state_e                state_q, state_d;
   logic [IDX_BITS-1:0]   count_q, count_d;
   logic                  cap_valid_q, cap_valid_d;
   logic                  in_ready_d, out_valid_d;
   logic [IDX_BITS-1:0]   lut_sel_d;
   logic [DIGIT_BITS-1:0] lut_digit_d;
   logic                  accept_c, capture_c, compress_c;

   digits_t               digits_q;
   logic [WORD_BITS-1:0]  cap_q;
   cs_pair_t              acc_q;
   logic [ACC_BITS-1:0]   cap_ext;
   logic [ACC_BITS-1:0]   csa_sum, csa_carry;

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      cap_valid_d = cap_valid_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      lut_sel_d   = '0;
      lut_digit_d = '0;
      accept_c    = 1'b0;
      capture_c   = 1'b0;
      compress_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready) begin
               accept_c    = 1'b1;
               state_d     = FETCH;
               count_d     = '0;
               cap_valid_d = 1'b0;
               in_ready_d  = 1'b0;
               lut_digit_d = in_digits[DIGIT_BITS-1:0];
            end
         end
         FETCH: begin
            capture_c   = 1'b1;
            cap_valid_d = 1'b1;
            compress_c  = cap_valid_q;
            count_d     = IDX_BITS'(count_q + 1'b1);
            if (count_q == IDX_BITS'(NUM_DIGITS - 1)) begin
               state_d = DRAIN;
            end else begin
               lut_sel_d   = count_d;
               lut_digit_d = digits_q[count_d];
            end
         end
         DRAIN: begin
            compress_c  = 1'b1;
            cap_valid_d = 1'b0;
            state_d     = DONE;
            out_valid_d = 1'b1;
         end
         DONE: begin
            if (out_ready) begin
               state_d    = IDLE;
               in_ready_d = 1'b1;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         cap_valid_q <= 1'b0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         lut_sel     <= '0;
         lut_digit   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         cap_valid_q <= cap_valid_d;
         in_ready    <= in_ready_d;
         out_valid   <= out_valid_d;
         lut_sel     <= lut_sel_d;
         lut_digit   <= lut_digit_d;
      end
   end

   assign cap_ext = {{(ACC_BITS - WORD_BITS){1'b0}}, cap_q};

   csa_3to2 #(
      .W(ACC_BITS)
   ) u_csa (
      .a       (acc_q.sum),
      .b       (acc_q.carry),
      .c       (cap_ext),
      .sum_c   (csa_sum),
      .carry_c (csa_carry)
   );

   // Capture is one cycle behind the LUT, accumulation one cycle behind capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q <= '0;
         cap_q    <= '0;
         acc_q    <= '0;
      end else begin
         if (accept_c) begin
            digits_q <= in_digits;
            acc_q    <= '0;
         end else if (compress_c) begin
            acc_q.sum   <= csa_sum;
            acc_q.carry <= csa_carry;
         end
         if (capture_c) begin
            cap_q <= lut_data;
         end
      end
   end

   assign out_sum   = acc_q.sum;
   assign out_carry = acc_q.carry;

endmodule

// File: tb/tb_xpb_digit_accumulator.sv
// Self-checking bench for xpb_digit_accumulator: directed table, handshake corners, random jobs.
module tb_xpb_digit_accumulator;
   import xpb_pkg::*;

   localparam int unsigned DW = NUM_DIGITS * DIGIT_BITS;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  in_valid;
   logic                  in_ready;
   logic [DW-1:0]         in_digits;
   logic [IDX_BITS-1:0]   lut_sel;
   logic [DIGIT_BITS-1:0] lut_digit;
   logic [WORD_BITS-1:0]  lut_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_BITS-1:0]   out_sum;
   logic [ACC_BITS-1:0]   out_carry;

   int                    lut_mode;
   logic [WORD_BITS-1:0]  rand_word [NUM_DIGITS];
   int                    checks = 0;
   int                    errors = 0;

   xpb_digit_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_digits (in_digits),
      .lut_sel   (lut_sel),
      .lut_digit (lut_digit),
      .lut_data  (lut_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry)
   );

   always #5 clk = ~clk;

   // LUT bank model: 0 = (sel+1)*digit, 1 = all ones, 2 = random word per position (0 for digit 0).
   always_comb begin
      case (lut_mode)
         1:       lut_data = '1;
         2:       lut_data = (lut_digit == '0) ? '0 : rand_word[lut_sel];
         default: lut_data = WORD_BITS'((32'(lut_sel) + 32'd1) * 32'(lut_digit));
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [ACC_BITS-1:0] got, input logic [ACC_BITS-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h..%h exp=%h..%h", name, got[ACC_BITS-1:ACC_BITS-64], got[63:0],
                  exp[ACC_BITS-1:ACC_BITS-64], exp[63:0]);
      end
   endtask

   // Reference: the plain sum of every lookup the LUT model would return for this job.
   function automatic logic [ACC_BITS-1:0] ref_total(input logic [DW-1:0] d, input int mode);
      logic [ACC_BITS-1:0] t;
      logic [DIGIT_BITS-1:0] dig;
      t = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         dig = d[i*DIGIT_BITS +: DIGIT_BITS];
         if (mode == 1)      t = t + {{(ACC_BITS-WORD_BITS){1'b0}}, {WORD_BITS{1'b1}}};
         else if (mode == 2) t = t + ((dig == '0) ? '0 : {{(ACC_BITS-WORD_BITS){1'b0}}, rand_word[i]});
         else                t = t + ACC_BITS'((i + 1) * int'(dig));
      end
      return t;
   endfunction

   // Offer one job, follow the LUT sweep, check latency and result, optionally stall, then release.
   task automatic run_job(input string name, input logic [DW-1:0] d, input int mode,
                          input logic [ACC_BITS-1:0] exp, input int hold);
      int cyc;
      logic [DIGIT_BITS-1:0] exp_dig;
      lut_mode = mode;
      for (int k = 0; k < 50 && !in_ready; k++) tick();
      chk({name, "_in_ready_before"}, ACC_BITS'(in_ready), ACC_BITS'(1));
      in_valid  = 1'b1;
      in_digits = d;
      tick();
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         if (cyc <= int'(NUM_DIGITS)) begin
            exp_dig = d[(cyc-1)*DIGIT_BITS +: DIGIT_BITS];
            chk({name, "_lut_sel"}, ACC_BITS'(lut_sel), ACC_BITS'(cyc - 1));
            chk({name, "_lut_digit"}, ACC_BITS'(lut_digit), ACC_BITS'(exp_dig));
         end else begin
            chk({name, "_lut_idle"}, ACC_BITS'({lut_sel, lut_digit}), '0);
         end
         chk({name, "_in_ready_busy"}, ACC_BITS'(in_ready), '0);
         tick();
         cyc++;
      end
      chk({name, "_latency"}, ACC_BITS'(cyc), ACC_BITS'(NUM_DIGITS + 2));
      chk({name, "_total"}, out_sum + out_carry, exp);
      for (int h = 0; h < hold; h++) begin
         in_valid  = 1'b1;
         in_digits = DW'({$urandom, $urandom});
         tick();
         chk({name, "_hold_valid"}, ACC_BITS'(out_valid), ACC_BITS'(1));
         chk({name, "_hold_in_ready"}, ACC_BITS'(in_ready), '0);
         chk({name, "_hold_total"}, out_sum + out_carry, exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, "_release_valid"}, ACC_BITS'(out_valid), '0);
      chk({name, "_release_in_ready"}, ACC_BITS'(in_ready), ACC_BITS'(1));
   endtask

   typedef struct {
      string               name;
      logic [DW-1:0]       digits;
      int                  mode;
      logic [ACC_BITS-1:0] exp;
   } vec_t;

   vec_t          vecs [4];
   logic [DW-1:0] ramp;
   logic [DW-1:0] d;
   int            mode;
   logic          seen;

   initial begin
      vecs[0] = '{"ones",     {NUM_DIGITS{5'd1}},  0, ACC_BITS'(36)};
      vecs[1] = '{"all31",    {NUM_DIGITS{5'd31}}, 0, ACC_BITS'(1116)};
      vecs[2] = '{"maxword",  {NUM_DIGITS{5'd31}}, 1, (ACC_BITS'(1) << (ACC_BITS-1)) - ACC_BITS'(8)};
      vecs[3] = '{"zeros",    '0,                  0, '0};
      for (int i = 0; i < int'(NUM_DIGITS); i++) ramp[i*DIGIT_BITS +: DIGIT_BITS] = DIGIT_BITS'(i);
      for (int i = 0; i < int'(NUM_DIGITS); i++) rand_word[i] = '0;

      lut_mode  = 0;
      in_valid  = 1'b0;
      in_digits = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #23;
      chk("reset_in_ready", ACC_BITS'(in_ready), ACC_BITS'(1));
      chk("reset_out_valid", ACC_BITS'(out_valid), '0);
      chk("reset_lut", ACC_BITS'({lut_sel, lut_digit}), '0);
      chk("reset_sum", out_sum, '0);
      chk("reset_carry", out_carry, '0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[v]) run_job(vecs[v].name, vecs[v].digits, vecs[v].mode, vecs[v].exp, 0);

      // Stalled result must hold; a new offer during DONE is dropped; the next job still runs clean.
      run_job("stall", {NUM_DIGITS{5'd1}}, 0, ACC_BITS'(36), 20);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         seen = seen | out_valid;
      end
      chk("stall_no_ghost_job", ACC_BITS'(seen), '0);
      run_job("ramp", ramp, 0, ACC_BITS'(168), 0);

      // Abort a job mid-fetch with reset.
      lut_mode  = 0;
      in_valid  = 1'b1;
      in_digits = {NUM_DIGITS{5'd31}};
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", ACC_BITS'(out_valid), '0);
      chk("abort_in_ready", ACC_BITS'(in_ready), ACC_BITS'(1));
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         seen = seen | out_valid;
      end
      chk("abort_no_valid", ACC_BITS'(seen), '0);
      chk("abort_in_ready_after", ACC_BITS'(in_ready), ACC_BITS'(1));
      run_job("after_abort", ramp, 0, ACC_BITS'(168), 0);

      // Random jobs against the reference sum.
      for (int j = 0; j < 20; j++) begin
         d    = DW'({$urandom, $urandom});
         mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
         if (mode == 2) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++)
               for (int w = 0; w < int'(WORD_BITS / 32); w++)
                  rand_word[i][w*32 +: 32] = $urandom;
         end
         run_job("random", d, mode, ref_total(d, mode), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/xpb_digit_accumulator.md
Name: xpb_digit_accumulator

Overview:
- Sequential reduction front-end for the 1024-bit modular squarer.
- Accepts one job of NUM_DIGITS 5-bit digits taken from the upper part of an unreduced square.
- Drives the xpb lookup bank one digit per cycle and sums the returned 1024-bit residues into a carry-save pair.
- The downstream final-add/reduce stage consumes that pair through a valid/ready handshake.

Parameters:
- DIGIT_BITS, 5, width of one digit and of each LUT select.
- NUM_DIGITS, 8, number of digits (LUT lookups) per job.
- WORD_BITS, 1024, width of each LUT result.
- ACC_BITS, 1028, accumulator width. Must satisfy ACC_BITS ≥ WORD_BITS + clog2(NUM_DIGITS).
- IDX_BITS, 3, width of the digit position index. Equals clog2(NUM_DIGITS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  block can accept a job.
- in_digits  in  NUM_DIGITS*DIGIT_BITS  digit i at bits [i*DIGIT_BITS +: DIGIT_BITS].
- lut_sel  out  IDX_BITS  digit position currently presented to the LUT bank.
- lut_digit  out  DIGIT_BITS  digit value presented to the LUT bank.
- lut_data  in  WORD_BITS  combinational LUT bank result for (lut_sel, lut_digit), same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_BITS  carry-save sum vector.
- out_carry  out  ACC_BITS  carry-save carry vector. out_sum + out_carry (mod 2^ACC_BITS) equals the sum of all lookups.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, in_ready=1, out_valid=0.
  - lut_sel=0, lut_digit=0, out_sum=0, out_carry=0.
  - Internal count, capture register and capture-valid flag all cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_digits, clear sum/carry/count/cap_valid, go to FETCH.
  - FETCH: in_ready=0. Per cycle: lut_sel=count, lut_digit=digit[count]. Register lut_data into the capture register and set cap_valid. If cap_valid was already set, compress the previous capture into sum/carry (3:2). Increment count. After count=NUM_DIGITS-1, go to DRAIN.
  - DRAIN: compress the final capture, clear cap_valid, go to DONE.
  - DONE: out_valid=1. out_sum/out_carry held stable while out_ready=0. On out_ready, out_valid falls next cycle and state returns to IDLE.
- Latency: out_valid rises NUM_DIGITS+2 cycles after the accepting edge (10 for the default).
- Throughput: one job per NUM_DIGITS+3 cycles minimum. There is no acceptance in DONE (no overlap).
- Outside FETCH, lut_sel/lut_digit hold 0.
- A zero digit is still looked up and accumulated (the LUT returns 0), so latency is fixed and data-independent.
- Arithmetic:
  - sum' = a ^ b ^ c.
  - carry' = ((a&b)|(a&c)|(b&c)) << 1, truncated to ACC_BITS.
  - lut_data is zero-extended.
  - Wrap mod 2^ACC_BITS is legal because the true sum is < NUM_DIGITS·2^WORD_BITS.
- in_valid while not IDLE: ignored; in_ready=0, and the upstream holds its data.
- out_ready while not DONE: ignored.
- rst_n low mid-job: the job is discarded. Restart in IDLE with no out_valid glitch.

Decomposition:
- Shared package xpb_pkg holds:
  - constants DIGIT_BITS, WORD_BITS, NUM_DIGITS;
  - derived ACC_BITS and IDX_BITS;
  - state enum {IDLE, FETCH, DRAIN, DONE};
  - clog2 function.
- One natural sub-module, csa_3to2: parameterised ACC_BITS-wide carry-save compressor, purely combinational, used for the accumulate step.

Test Plan:
- Bench LUT model returns lut_data=(lut_sel+1)*lut_digit.
  - Digits all 5'd1 → out_valid at cycle 10; out_sum+out_carry=36.
  - Digits all 5'd31 → out_sum+out_carry=1116.
- Model returns 2^1024-1 for every lookup, digits all 31 → out_sum+out_carry = 8·(2^1024-1) mod 2^1028. Checks no overflow loss.
- Backpressure: out_ready=0 for 20 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 → IDLE, and a second job (digits 0..7 as 0,1,…,7) gives sum of (i+1)*i = 168.
- Digits all zero → lut_sel sweeps 0..7 during FETCH; result 0; latency still 10.
- Assert rst_n low at cycle 4 of a job → out_valid never rises, in_ready=1 after release, and the next job's result is correct (no residue from the aborted job).
